sqrt_sched: RTL and testbench
=============================

SQRT_SCHED -- requirements
Module: sqrt_sched

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing the engine (2..8).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port req_valid, input, NUM_REQ, per-requester request valid.
REQ-005 SHALL have port req_ready, output, NUM_REQ, per-requester grant; at most one bit high per cycle.
REQ-006 SHALL have port req_x, input, NUM_REQ x 32, per-requester unsigned radicand.
REQ-007 SHALL have port rsp_valid, output, 1, result valid.
REQ-008 SHALL have port rsp_ready, input, 1, consumer accepts the result.
REQ-009 SHALL have port rsp_id, output, $clog2(NUM_REQ), index of the requester that owns the result.
REQ-010 SHALL have port rsp_root, output, 16, floor(sqrt(x)).
REQ-011 SHALL have port rsp_rem, output, 17, x - root*root.
REQ-012 SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, CALC and DONE.
REQ-014 In IDLE, SHALL assert req_ready for exactly one requester with req_valid high; that requester is the first at or after rr_ptr in ascending modulo order.
REQ-015 req_ready SHALL be low in CALC and DONE, and low in IDLE when no req_valid bit is high.
REQ-016 An accept (req_valid[i] & req_ready[i]) SHALL latch req_x[i] and i, clear the iteration counter and move to CALC.
REQ-017 On accept, rr_ptr SHALL be set to (i+1) mod NUM_REQ.
REQ-018 In CALC, SHALL resolve one root bit per cycle, MSB first, using non-restoring/restoring digit recurrence; no multiplier.
REQ-019 CALC SHALL last exactly 16 cycles; rsp_valid SHALL rise on the 16th rising edge after the accept edge.
REQ-020 Latency SHALL be independent of x; x=0 has no shortcut.
REQ-021 In DONE, rsp_valid, rsp_id, rsp_root and rsp_rem SHALL be held stable until rsp_valid & rsp_ready.
REQ-022 On the rsp handshake, SHALL return to IDLE; a new accept is possible on the following cycle, never in the same cycle.
REQ-023 rsp_valid SHALL be low outside DONE; rsp_root, rsp_rem and rsp_id SHALL hold the last result when not valid.
REQ-024 Results SHALL be exact for the full 32-bit range; rsp_rem SHALL not exceed 2*root and SHALL never be truncated.
REQ-025 Changes on req_x or req_valid after accept SHALL not affect the in-flight computation.

Reset
REQ-026 rst SHALL force state IDLE, rr_ptr 0, iteration counter 0, req_ready 0, rsp_valid 0, busy 0, rsp_id 0, rsp_root 0, rsp_rem 0.
REQ-027 rst asserted mid-CALC or in DONE SHALL discard the in-flight result with no rsp_valid pulse; the dropped requester is not re-served automatically.
REQ-028 req_ready SHALL be 0 in the cycle rst is high, regardless of req_valid.

Structure
REQ-029 Package sqrt_pkg SHALL hold X_W=32, ROOT_W=16, REM_W=17, and the state enum type.
REQ-030 The one-bit recurrence step SHALL be the combinational sub-module sqrt_step (inputs: partial remainder, partial root, next two radicand bits; outputs: updated remainder and root); the FSM and arbiter stay in sqrt_sched.

Verification
REQ-031 Single request: req_x[0]=0xFFFFFFFF -> accept, rsp_valid 16 cycles later with root=0xFFFF, rem=0x1FFFE, id=0.
REQ-032 Boundaries: x=0 -> root 0, rem 0; x=1 -> 1, 0; x=15 -> 3, 6; x=16 -> 4, 0; each at 16-cycle latency.
REQ-033 Fairness: all 4 req_valid held high with distinct x -> grant order 0,1,2,3,0; rsp_id matches each accepted index.
REQ-034 Backpressure: rsp_ready held low 5 cycles in DONE -> outputs stable, req_ready all 0; rsp_ready high -> IDLE, next grant one cycle later.
REQ-035 Reset mid-CALC: rst at cycle 8 of CALC -> no rsp_valid, all outputs 0, next grant goes to requester 0.
REQ-036 Random: 10k random x across all requesters against a reference model -> root^2 <= x < (root+1)^2 and rem = x - root^2.

Source files
------------

// File: rtl/sqrt_pkg.sv
// Shared widths, counter limit and FSM state type for the shared square-root engine.
package sqrt_pkg;

   localparam int X_W    = 32;
   localparam int ROOT_W = 16;
   localparam int REM_W  = 17;
   localparam int CNT_W  = 4;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ROOT_W - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/sqrt_step.sv
// One restoring digit-recurrence step: resolves the next root bit from two radicand bits.
module sqrt_step
   import sqrt_pkg::*;
(
   input  logic [REM_W-1:0]  i_rem,
   input  logic [ROOT_W-1:0] i_root,
   input  logic [1:0]        i_bits,
   output logic [REM_W-1:0]  o_rem,
   output logic [ROOT_W-1:0] o_root
);

   logic [REM_W+1:0] w_cat;
   logic [REM_W+1:0] w_d;
   logic [REM_W-1:0] w_diff;
   logic             w_ge;

   assign w_cat = {i_rem, i_bits};
   assign w_d   = {1'b0, i_root, 2'b01};
   assign w_ge  = (w_cat >= w_d);

   // A kept difference never exceeds 2*root, so the low REM_W bits are exact.
   assign w_diff = w_cat[REM_W-1:0] - w_d[REM_W-1:0];

   assign o_rem  = w_ge ? w_diff : w_cat[REM_W-1:0];
   assign o_root = {i_root[ROOT_W-2:0], w_ge};

endmodule

// File: rtl/sqrt_sched.sv
// Round-robin arbiter in front of a 16-cycle bit-serial integer square-root engine.
module sqrt_sched
   import sqrt_pkg::*;
#(
   parameter int NUM_REQ = 4
)
(
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         req_valid,
   output logic [NUM_REQ-1:0]         req_ready,
   input  logic [NUM_REQ*X_W-1:0]     req_x,
   output logic                       rsp_valid,
   input  logic                       rsp_ready,
   output logic [$clog2(NUM_REQ)-1:0] rsp_id,
   output logic [ROOT_W-1:0]          rsp_root,
   output logic [REM_W-1:0]           rsp_rem,
   output logic                       busy
);

   localparam int ID_W = $clog2(NUM_REQ);

   state_t            r_state;
   state_t            w_next;
   logic [ID_W-1:0]   r_rr_ptr;
   logic [ID_W-1:0]   r_id;
   logic [ID_W-1:0]   r_rsp_id;
   logic [ID_W-1:0]   w_gnt_idx;
   logic [ID_W-1:0]   w_ptr_next;
   logic              w_found;
   logic              w_accept;
   logic [CNT_W-1:0]  r_cnt;
   logic [X_W-1:0]    r_x;
   logic [REM_W-1:0]  r_rem;
   logic [REM_W-1:0]  w_rem;
   logic [REM_W-1:0]  r_rsp_rem;
   logic [ROOT_W-1:0] r_root;
   logic [ROOT_W-1:0] w_root;
   logic [ROOT_W-1:0] r_rsp_root;

   // First valid requester at or after the round-robin pointer, modulo NUM_REQ.
   always_comb begin
      int v_idx;
      // NOTE: every combinational output gets a default first so no path infers a latch.
      v_idx     = 0;
      w_found   = 1'b0;
      w_gnt_idx = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         v_idx = int'(r_rr_ptr) + k;
         if (v_idx >= NUM_REQ) v_idx = v_idx - NUM_REQ;
         if (!w_found && req_valid[v_idx]) begin
            w_found   = 1'b1;
            w_gnt_idx = ID_W'(v_idx);
         end
      end
   end

   assign w_ptr_next = (w_gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next    = r_state;
      req_ready = '0;
      w_accept  = 1'b0;
      rsp_valid = 1'b0;
      busy      = 1'b1;
      case (r_state)
         IDLE: begin
            busy = 1'b0;
            if (w_found && !rst) begin
               req_ready[w_gnt_idx] = 1'b1;
               w_accept             = 1'b1;
               w_next               = CALC;
            end
         end
         CALC: if (r_cnt == CNT_LAST) w_next = DONE;
         DONE: begin
            rsp_valid = !rst;
            if (rsp_ready) w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   sqrt_step u_step (
      .i_rem  (r_rem),
      .i_root (r_root),
      .i_bits (r_x[X_W-1 -: 2]),
      .o_rem  (w_rem),
      .o_root (w_root)
   );

   always_ff @(posedge clk) begin
      // NOTE: datapath is reset too, so a dropped job leaves no stale result on the outputs.
      if (rst) begin
         r_rr_ptr   <= '0;
         r_id       <= '0;
         r_cnt      <= '0;
         r_x        <= '0;
         r_rem      <= '0;
         r_root     <= '0;
         r_rsp_id   <= '0;
         r_rsp_root <= '0;
         r_rsp_rem  <= '0;
      end else if (w_accept) begin
         r_x      <= req_x[int'(w_gnt_idx)*X_W +: X_W];
         r_id     <= w_gnt_idx;
         r_rr_ptr <= w_ptr_next;
         r_cnt    <= '0;
         r_rem    <= '0;
         r_root   <= '0;
      end else if (r_state == CALC) begin
         r_x    <= {r_x[X_W-3:0], 2'b00};
         r_rem  <= w_rem;
         r_root <= w_root;
         r_cnt  <= r_cnt + 1'b1;
         if (r_cnt == CNT_LAST) begin
            r_rsp_id   <= r_id;
            r_rsp_root <= w_root;
            r_rsp_rem  <= w_rem;
         end
      end
   end

   assign rsp_id   = r_rsp_id;
   assign rsp_root = r_rsp_root;
   assign rsp_rem  = r_rsp_rem;

endmodule

// File: tb/tb_sqrt_sched.sv
// Self-checking bench for sqrt_sched: transaction-level model plus directed literal cases.
module tb_sqrt_sched;

   localparam int N        = 4;
   localparam int PH_IDLE  = 0;
   localparam int PH_CALC  = 1;
   localparam int PH_DONE  = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic [N-1:0]      req_valid;
   logic [N-1:0]      req_ready;
   logic [N*32-1:0]   req_x;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [1:0]        rsp_id;
   logic [15:0]       rsp_root;
   logic [16:0]       rsp_rem;
   logic              busy;

   int n_pass  = 0;
   int n_total = 0;

   int      m_phase = PH_IDLE;
   int      m_ptr   = 0;
   int      m_left  = 0;
   int      m_owner = 0;
   longint  m_x     = 0;
   longint  m_id    = 0;
   longint  m_root  = 0;
   longint  m_rem   = 0;
   int      grants[$];

   sqrt_sched #(.NUM_REQ(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_x     (req_x),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_root  (rsp_root),
      .rsp_rem   (rsp_rem),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input longint got, input longint exp);
      n_total++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
   endtask

   function automatic longint isqrt(input longint x);
      longint r;
      r = longint'($sqrt(real'(x)));
      while (r * r > x) r--;
      while ((r + 1) * (r + 1) <= x) r++;
      return r;
   endfunction

   function automatic int first_idx(input logic [N-1:0] v, input int ptr);
      for (int k = 0; k < N; k++)
         if (v[(ptr + k) % N]) return (ptr + k) % N;
      return -1;
   endfunction

   // Transaction-level model: a job occupies the engine for 16 edges, then waits for rsp_ready.
   always @(posedge clk) begin
      int g;
      if (rst) begin
         m_phase = PH_IDLE;
         m_ptr   = 0;
         m_id    = 0;
         m_root  = 0;
         m_rem   = 0;
      end else begin
         case (m_phase)
            PH_IDLE: begin
               g = first_idx(req_valid, m_ptr);
               if (g >= 0) begin
                  m_x     = longint'(req_x[g*32 +: 32]);
                  m_owner = g;
                  m_ptr   = (g + 1) % N;
                  m_left  = 16;
                  m_phase = PH_CALC;
                  grants.push_back(g);
               end
            end
            PH_CALC: begin
               m_left--;
               if (m_left == 0) begin
                  m_root  = isqrt(m_x);
                  m_rem   = m_x - m_root * m_root;
                  m_id    = m_owner;
                  m_phase = PH_DONE;
               end
            end
            default: if (rsp_ready) m_phase = PH_IDLE;
         endcase
      end
   end

   always @(negedge clk) begin
      logic [N-1:0] e_ready;
      longint       r;
      int           g;
      g       = first_idx(req_valid, m_ptr);
      e_ready = '0;
      if (!rst && m_phase == PH_IDLE && g >= 0) e_ready[g] = 1'b1;
      check("req_ready", req_ready, e_ready);
      check("rsp_valid", rsp_valid, (m_phase == PH_DONE && !rst));
      check("busy", busy, (m_phase != PH_IDLE));
      check("rsp_id", rsp_id, m_id);
      check("rsp_root", rsp_root, m_root);
      check("rsp_rem", rsp_rem, m_rem);
      if (rsp_valid && rsp_ready && !rst) begin
         r = longint'(rsp_root);
         check("root_sq_le_x", (r * r <= m_x), 1);
         check("x_lt_next_sq", (m_x < (r + 1) * (r + 1)), 1);
         check("rem_exact", longint'(rsp_rem), m_x - r * r);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_x(input int idx, input logic [31:0] x);
      req_x[idx*32 +: 32] = x;
   endtask

   task automatic wait_rsp(output int n);
      n = 0;
      while (!rsp_valid && n < 40) begin
         tick();
         n++;
      end
   endtask

   task automatic wait_grant(input int idx, input string tag);
      int n;
      #1;
      n = 0;
      while (!req_ready[idx] && n < 50) begin
         tick();
         n++;
      end
      check({tag, "_grant"}, req_ready[idx], 1);
   endtask

   task automatic run_one(input int idx, input logic [31:0] x, input longint er,
                          input longint erem, input string tag);
      int n;
      set_x(idx, x);
      req_valid      = '0;
      req_valid[idx] = 1'b1;
      wait_grant(idx, tag);
      tick();
      req_valid = '0;
      wait_rsp(n);
      check({tag, "_latency"}, n, 16);
      check({tag, "_root"}, rsp_root, er);
      check({tag, "_rem"}, rsp_rem, erem);
      check({tag, "_id"}, rsp_id, idx);
      tick();
   endtask

   function automatic logic [31:0] rand_x();
      logic [31:0] r;
      case ($urandom_range(0, 4))
         0: return 32'd0;
         1: return 32'hFFFF_FFFF;
         2: begin
            r = 32'($urandom_range(0, 65535));
            return r * r + 32'($urandom_range(0, 2)) - 32'd1;
         end
         default: return 32'($urandom);
      endcase
   endfunction

   initial begin
      int n;
      logic [15:0] h_root;
      logic [16:0] h_rem;
      rst       = 1'b1;
      req_valid = '1;
      req_x     = '0;
      rsp_ready = 1'b1;
      tick();
      tick();
      check("rst_req_ready", req_ready, 0);
      check("rst_busy", busy, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_root", rsp_root, 0);
      rst       = 1'b0;
      req_valid = '0;
      tick();

      run_one(0, 32'hFFFF_FFFF, 64'hFFFF, 64'h1FFFE, "max");
      run_one(1, 32'd0,  0, 0, "x0");
      run_one(2, 32'd1,  1, 0, "x1");
      run_one(3, 32'd15, 3, 6, "x15");
      run_one(0, 32'd16, 4, 0, "x16");

      // Backpressure: requester 1 served, everyone else keeps asking while the result is held.
      rsp_ready = 1'b0;
      set_x(1, 32'd1000001);
      req_valid = 4'b0010;
      wait_grant(1, "bp");
      tick();
      req_valid = 4'b1111;
      wait_rsp(n);
      check("bp_latency", n, 16);
      for (int i = 0; i < 5; i++) begin
         check("bp_valid", rsp_valid, 1);
         check("bp_root", rsp_root, 1000);
         check("bp_rem", rsp_rem, 1);
         check("bp_ready_low", req_ready, 0);
         tick();
      end
      rsp_ready = 1'b1;
      tick();
      check("bp_idle", busy, 0);
      check("bp_next_grant", req_ready, 4'b0100);
      tick();
      req_valid = '0;
      wait_rsp(n);
      tick();

      // Reset in the eighth CALC cycle drops the job; the pointer returns to requester 0.
      set_x(2, 32'h1234_5678);
      req_valid = 4'b0100;
      wait_grant(2, "mid");
      tick();
      req_valid = '0;
      repeat (7) tick();
      check("mid_busy", busy, 1);
      rst       = 1'b1;
      req_valid = '1;
      #1;
      check("mid_rst_ready", req_ready, 0);
      tick();
      rst       = 1'b0;
      req_valid = '0;
      check("mid_root", rsp_root, 0);
      check("mid_rem", rsp_rem, 0);
      check("mid_id", rsp_id, 0);
      check("mid_busy0", busy, 0);
      n = 0;
      for (int i = 0; i < 20; i++) begin
         if (rsp_valid) n++;
         tick();
      end
      check("mid_no_rsp", n, 0);

      // Fairness: everyone asks continuously with distinct radicands.
      for (int i = 0; i < N; i++) set_x(i, 32'(100 * (i + 1) + 7));
      grants.delete();
      req_valid = '1;
      #1;
      check("fair_first", req_ready, 4'b0001);
      n = 0;
      while (grants.size() < 5 && n < 200) begin
         tick();
         n++;
      end
      check("fair_count", grants.size() >= 5, 1);
      if (grants.size() >= 5) begin
         check("fair_g0", grants[0], 0);
         check("fair_g1", grants[1], 1);
         check("fair_g2", grants[2], 2);
         check("fair_g3", grants[3], 3);
         check("fair_g4", grants[4], 0);
      end
      req_valid = '0;
      n = 0;
      while (busy && n < 50) begin
         tick();
         n++;
      end
      check("fair_drain", busy, 0);

      // Random traffic with corner radicands, changing inputs mid-flight and rare resets.
      for (int c = 0; c < 30000; c++) begin
         for (int i = 0; i < N; i++) set_x(i, rand_x());
         req_valid = 4'($urandom_range(0, 15));
         rsp_ready = ($urandom_range(0, 3) != 0);
         rst       = ($urandom_range(0, 1999) == 0);
         tick();
      end
      rst       = 1'b0;
      req_valid = '0;
      rsp_ready = 1'b1;
      repeat (40) tick();
      check("end_idle", busy, 0);

      h_root = rsp_root;
      h_rem  = rsp_rem;
      check("model_pin_rem", isqrt(64'd99) * isqrt(64'd99) + 64'd18, 64'd99);
      check("hold_root", rsp_root, h_root);
      check("hold_rem", rsp_rem, h_rem);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
